// File: rtl/vshift_sequencer_if.sv
// -----------------------------------------------------------------------------
// vshift_sequencer_if
// Bundles every non-clock/reset signal of the vector shift sequencer: the issue
// request handshake, the VRF read port, the external shifter operands/result,
// the VRF write port and the completion pulses.
//   master : the sequencer itself (drives rd_*, shift_*, wr_*, done/err, ready)
//   slave  : the surrounding issue logic / VRF / shifter
// Signal names keep the _i/_o suffixes as seen from the sequencer.
// -----------------------------------------------------------------------------
interface vshift_sequencer_if #(
  parameter int CHUNK_W = 128
);
  // issue request
  logic               req_valid_i;
  logic               req_ready_o;
  logic [2:0]         req_vsew_i;
  logic [7:0]         req_vl_i;
  logic [3:0]         req_lmul_i;
  logic [4:0]         req_vs2_i;
  logic [4:0]         req_vs1_i;
  logic [4:0]         req_vd_i;
  // VRF read port
  logic               rd_en_o;
  logic [4:0]         rd_vs2_o;
  logic [4:0]         rd_vs1_o;
  logic [2:0]         rd_chunk_o;
  logic [CHUNK_W-1:0] rd_data_a_i;
  logic [CHUNK_W-1:0] rd_data_b_i;
  // external combinational shifter
  logic [2:0]         shift_vsew_o;
  logic [CHUNK_W-1:0] shift_a_o;
  logic [CHUNK_W-1:0] shift_b_o;
  logic [CHUNK_W-1:0] shift_s_i;
  // VRF write port
  logic                 wr_valid_o;
  logic                 wr_ready_i;
  logic [4:0]           wr_vd_o;
  logic [2:0]           wr_chunk_o;
  logic [CHUNK_W-1:0]   wr_data_o;
  logic [CHUNK_W/8-1:0] wr_be_o;
  // completion
  logic               done_o;
  logic               err_o;

  modport master (
    input  req_valid_i, req_vsew_i, req_vl_i, req_lmul_i,
    input  req_vs2_i, req_vs1_i, req_vd_i,
    output req_ready_o,
    output rd_en_o, rd_vs2_o, rd_vs1_o, rd_chunk_o,
    input  rd_data_a_i, rd_data_b_i,
    output shift_vsew_o, shift_a_o, shift_b_o,
    input  shift_s_i,
    output wr_valid_o, wr_vd_o, wr_chunk_o, wr_data_o, wr_be_o,
    input  wr_ready_i,
    output done_o, err_o
  );

  modport slave (
    output req_valid_i, req_vsew_i, req_vl_i, req_lmul_i,
    output req_vs2_i, req_vs1_i, req_vd_i,
    input  req_ready_o,
    input  rd_en_o, rd_vs2_o, rd_vs1_o, rd_chunk_o,
    output rd_data_a_i, rd_data_b_i,
    input  shift_vsew_o, shift_a_o, shift_b_o,
    output shift_s_i,
    input  wr_valid_o, wr_vd_o, wr_chunk_o, wr_data_o, wr_be_o,
    output wr_ready_i,
    input  done_o, err_o
  );
endinterface

// File: rtl/vshift_sequencer.sv
// -----------------------------------------------------------------------------
// vshift_sequencer
// Walks a vector right-shift across a register group one 128-bit chunk at a
// time: read vs2/vs1 chunk, register operands for the external shifter, write
// the shifter result to vd with a tail byte mask, then pulse done.
// Ports:
//   clk_i  : clock
//   rsn_i  : asynchronous active-low reset
//   bus    : vshift_sequencer_if.master (request, VRF read, shifter, VRF write,
//            done/err)
// -----------------------------------------------------------------------------
module vshift_sequencer #(
  parameter int CHUNK_W    = 128,
  parameter int MAX_CHUNKS = 8
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  vshift_sequencer_if.master  bus
);

  localparam int         NBYTES = CHUNK_W / 8;
  localparam logic [3:0] MAX_CH = 4'(MAX_CHUNKS);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]         state_reg, state_next;
  logic [2:0]         vsew_reg;
  logic [10:0]        vl_bytes_reg;
  logic [3:0]         nchunks_reg;
  logic [4:0]         vs2_reg, vs1_reg, vd_reg;
  logic [2:0]         chunk_reg;
  logic               err_reg;
  logic [CHUNK_W-1:0] op_a_reg, op_b_reg;

  // ---------------------------------------------------------------------------
  // Request decode, only meaningful in the accept cycle
  // ---------------------------------------------------------------------------
  logic        accept;
  logic        sew_ok;
  logic [10:0] req_vl_bytes;
  logic [7:0]  req_chunks_ceil;
  logic [3:0]  req_lmul_eff;
  logic [3:0]  req_nchunks;
  logic        last_chunk;

  assign accept = bus.req_valid_i && (state_reg == ST_IDLE);
  // SEW codes 1xx are reserved
  assign sew_ok = ~bus.req_vsew_i[2];
  // vl is at most 255 and SEW at most 8 bytes, so 11 bits never overflow
  assign req_vl_bytes = {3'b000, bus.req_vl_i} << bus.req_vsew_i[1:0];
  // ceil(bytes/16) without a carry-prone +15 adder
  assign req_chunks_ceil = {1'b0, req_vl_bytes[10:4]} + 8'(|req_vl_bytes[3:0]);

  always_comb begin
    req_lmul_eff = bus.req_lmul_i;
    if (bus.req_lmul_i == 4'd0) begin
      req_lmul_eff = 4'd1;
    end else if (bus.req_lmul_i > MAX_CH) begin
      req_lmul_eff = MAX_CH;
    end
  end

  always_comb begin
    req_nchunks = req_chunks_ceil[3:0];
    if ({4'b0000, req_lmul_eff} < req_chunks_ceil) begin
      req_nchunks = req_lmul_eff;
    end
  end

  assign last_chunk = ({1'b0, chunk_reg} == (nchunks_reg - 4'd1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          // invalid SEW or empty op completes without touching the VRF
          state_next = (sew_ok && (req_nchunks != 4'd0)) ? ST_RD : ST_DONE;
        end
      end
      ST_RD:   state_next = ST_WAIT;
      ST_WAIT: state_next = ST_WR;
      ST_WR: begin
        if (bus.wr_ready_i) begin
          state_next = last_chunk ? ST_DONE : ST_RD;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_reg    <= ST_IDLE;
      vsew_reg     <= 3'd0;
      vl_bytes_reg <= 11'd0;
      nchunks_reg  <= 4'd0;
      vs2_reg      <= 5'd0;
      vs1_reg      <= 5'd0;
      vd_reg       <= 5'd0;
      chunk_reg    <= 3'd0;
      err_reg      <= 1'b0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        vsew_reg     <= bus.req_vsew_i;
        vl_bytes_reg <= req_vl_bytes;
        nchunks_reg  <= req_nchunks;
        vs2_reg      <= bus.req_vs2_i;
        vs1_reg      <= bus.req_vs1_i;
        vd_reg       <= bus.req_vd_i;
        chunk_reg    <= 3'd0;
        err_reg      <= ~sew_ok;
      end
      // read data arrives the cycle after rd_en
      if (state_reg == ST_WAIT) begin
        op_a_reg <= bus.rd_data_a_i;
        op_b_reg <= bus.rd_data_b_i;
      end
      if ((state_reg == ST_WR) && bus.wr_ready_i && !last_chunk) begin
        chunk_reg <= chunk_reg + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tail byte mask: byte j of this chunk is live while its group offset < vl_bytes
  // ---------------------------------------------------------------------------
  logic [NBYTES-1:0] be;

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_be
      assign be[gi] = (({4'b0000, chunk_reg, 4'b0000} + 11'(gi)) < vl_bytes_reg);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready_o  = (state_reg == ST_IDLE);
  assign bus.rd_en_o      = (state_reg == ST_RD);
  assign bus.rd_vs2_o     = vs2_reg;
  assign bus.rd_vs1_o     = vs1_reg;
  assign bus.rd_chunk_o   = chunk_reg;
  assign bus.shift_vsew_o = vsew_reg;
  assign bus.shift_a_o    = op_a_reg;
  assign bus.shift_b_o    = op_b_reg;
  assign bus.wr_valid_o   = (state_reg == ST_WR);
  assign bus.wr_vd_o      = vd_reg;
  assign bus.wr_chunk_o   = chunk_reg;
  assign bus.wr_data_o    = bus.shift_s_i;
  assign bus.wr_be_o      = be;
  assign bus.done_o       = (state_reg == ST_DONE);
  assign bus.err_o        = (state_reg == ST_DONE) && err_reg;

endmodule

// File: doc/vshift_sequencer.md
Name: vshift_sequencer

Overview:
- Sequences the 128-bit vector right-shift datapath across a multi-register vector group (LMUL up to 8), one 128-bit chunk at a time.
- Accepts one shift request, reads vs2 (data) and vs1 (shift amounts) chunks from the vector register file, and drives the external combinational shifter.
- Writes each result chunk back to vd with a byte-enable mask derived from vl and SEW.
- Sits between vector issue logic and the VRF read/write ports.

Parameters:
- CHUNK_W, 128, shifter/VRF chunk width in bits (fixed; byte-mask logic sized CHUNK_W/8 = 16)
- MAX_CHUNKS, 8, maximum register-group size in chunks

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high only in IDLE
- req_vsew_i  in  3  SEW code: 000=8, 001=16, 010=32, 011=64, others invalid
- req_vl_i  in  8  active element count
- req_lmul_i  in  4  group size in chunks, 1..8 (0 treated as 1, >8 clipped to 8)
- req_vs2_i / req_vs1_i / req_vd_i  in  5 each  source data / shift-amount / destination register
- rd_en_o  out  1  VRF read strobe; data valid exactly one cycle later
- rd_vs2_o / rd_vs1_o  out  5 each  read register indices
- rd_chunk_o  out  3  chunk index within the group
- rd_data_a_i / rd_data_b_i  in  128 each  vs2 / vs1 chunk data
- shift_vsew_o  out  3  to shifter vsew_i
- shift_a_o / shift_b_o  out  128 each  to shifter a, b (registered operands)
- shift_s_i  in  128  shifter result (combinational from a, b, vsew)
- wr_valid_o  out  1  write valid
- wr_ready_i  in  1  write accept
- wr_vd_o  out  5  destination register
- wr_chunk_o  out  3  destination chunk
- wr_data_o  out  128  result data (= shift_s_i)
- wr_be_o  out  16  byte enables
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse with done_o for an invalid vsew

Behaviour:
- Reset (asynchronous, rsn_i=0):
  - state=IDLE.
  - All outputs 0, except req_ready_o=1.
  - Operand, chunk and config registers cleared.
  - Reset mid-operation abandons the op with no further writes.
- Accept:
  - req_valid_i & req_ready_o latches vsew, vl, lmul, vs2, vs1, vd.
  - vl_bytes = vl << sew (11 bits).
  - nchunks = min(ceil(vl_bytes/16), lmul_eff).
- FSM:
  - IDLE -> RD on accept. If vsew is invalid or nchunks==0, go IDLE -> DONE instead (err_o=1 if vsew invalid).
  - RD: rd_en_o=1 for one cycle with the current chunk index. -> WAIT.
  - WAIT: capture rd_data_a_i/b_i into the operand registers. -> WR.
  - WR: wr_valid_o=1; data, vd, chunk and be are held stable until wr_ready_i.
    - On handshake: if chunk==nchunks-1 -> DONE, else chunk+1 -> RD.
  - DONE: done_o=1 (plus err_o if applicable) for one cycle. -> IDLE.
- Latency:
  - Minimum 3 cycles per chunk.
  - Single-chunk op with wr_ready_i held high: done_o asserted 4 cycles after accept.
- Byte mask: wr_be_o[j] = (chunk*16 + j) < vl_bytes. Tail bytes are masked off; the shifter output is not modified.
- shift_vsew_o holds the latched vsew for the whole op.
- req_valid_i is ignored outside IDLE; no queueing.
- wr_ready_i stall: state, rd_en_o and chunk index frozen; no extra reads issued.

Test Plan:
- vsew=000, vl=16, lmul=1, vs2 chunk=0x80 in every byte, vs1 bytes=0x03 -> one write, wr_data=0x10 per byte, wr_be=0xFFFF, done_o 4 cycles after accept.
- vsew=010, vl=10, lmul=4 -> vl_bytes=40, 3 chunks; be = 0xFFFF, 0xFFFF, 0x00FF for chunks 0, 1, 2; wr_chunk 0..2; single done_o.
- vsew=011, vl=0 -> no rd_en_o, no wr_valid_o, done_o=1 one cycle after accept, err_o=0.
- vsew=101 -> no reads or writes, done_o=1 and err_o=1 in the same cycle.
- wr_ready_i held low 5 cycles during chunk 1 -> wr_valid_o and outputs stable, only 2 rd_en_o pulses total for a 2-chunk op, req_ready_o=0 throughout.
- rsn_i pulled low during WR of a 4-chunk op -> outputs cleared asynchronously, req_ready_o=1 after release, next request processed from chunk 0.
